// File: rtl/reg_alu_pkg.sv
// Shared definitions for the register-file execute/write-back stage:
// opcode values, FSM state encoding and register address width.
package reg_alu_pkg;

    localparam int ADDR_W = 3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MOV = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_EXEC = 3'd3,
        S_WB   = 3'd4
    } state_t;

endpackage

// File: rtl/reg_alu_sequencer_alu.sv
// Purely combinational N-bit ALU. carry is the ADD carry-out or the SUB
// unsigned borrow; it is 0 for every other opcode.
module alu_comb
    import reg_alu_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   op,
    output logic [N-1:0] y,
    output logic         carry
);

    logic [N:0] sum;
    logic [N:0] diff;

    // The extra top bit of the widened subtraction is set exactly when a < b.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        y     = '0;
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                y     = sum[N-1:0];
                carry = sum[N];
            end
            OP_SUB: begin
                y     = diff[N-1:0];
                carry = diff[N];
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SHL:  y = a << b[3:0];
            OP_SHR:  y = a >> b[3:0];
            default: y = a;
        endcase
    end

endmodule

// File: rtl/reg_alu_sequencer.sv
// Execute/write-back stage: reads two operands through the register file's
// single registered read port, runs the ALU, writes the result back.
module reg_alu_sequencer
    import reg_alu_pkg::*;
#(
    parameter int N = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic [ADDR_W-1:0] instr_rs1,
    input  logic [ADDR_W-1:0] instr_rs2,
    output logic              rf_read_enable,
    output logic [ADDR_W-1:0] rf_read_addr,
    input  logic [N-1:0]      rf_read_data,
    output logic              rf_write_enable,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [N-1:0]      rf_write_data,
    output logic              busy,
    output logic              done,
    output logic [N-1:0]      result,
    output logic              flag_zero,
    output logic              flag_carry
);

    state_t state;
    state_t state_next;

    logic [2:0]        op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [ADDR_W-1:0] rs1_q;
    logic [ADDR_W-1:0] rs2_q;
    logic [N-1:0]      op_a;
    logic [N-1:0]      alu_y;
    logic              alu_carry;

    // op_b is never stored: in EXEC the read port is still presenting rs2.
    alu_comb #(.N(N)) u_alu (
        .a     (op_a),
        .b     (rf_read_data),
        .op    (op_q),
        .y     (alu_y),
        .carry (alu_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        instr_ready     = 1'b0;
        busy            = 1'b1;
        rf_read_enable  = 1'b0;
        rf_read_addr    = '0;
        rf_write_enable = 1'b0;
        rf_write_addr   = '0;
        rf_write_data   = '0;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
                if (instr_valid) begin
                    state_next = S_RD_A;
                end
            end
            S_RD_A: begin
                rf_read_enable = 1'b1;
                rf_read_addr   = rs1_q;
                state_next     = S_RD_B;
            end
            S_RD_B: begin
                rf_read_enable = 1'b1;
                rf_read_addr   = rs2_q;
                state_next     = S_EXEC;
            end
            S_EXEC: begin
                state_next = S_WB;
            end
            S_WB: begin
                rf_write_enable = 1'b1;
                rf_write_addr   = rd_q;
                rf_write_data   = result;
                state_next      = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= OP_ADD;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            op_a       <= '0;
            result     <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= (state == S_WB);
            case (state)
                S_IDLE: begin
                    if (instr_valid && instr_ready) begin
                        op_q  <= instr_op;
                        rd_q  <= instr_rd;
                        rs1_q <= instr_rs1;
                        rs2_q <= instr_rs2;
                    end
                end
                S_RD_B: begin
                    op_a <= rf_read_data;
                end
                S_EXEC: begin
                    result     <= alu_y;
                    flag_zero  <= (alu_y == '0);
                    flag_carry <= alu_carry;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/reg_alu_sequencer.md
Name: reg_alu_sequencer

Overview:
Execute/write-back stage sitting directly downstream of the 8-entry register file.
- Accepts one register-to-register instruction at a time through a valid/ready handshake.
- Reads both source operands through the file's single registered read port, over two consecutive cycles.
- Computes an N-bit ALU result, writes it back to the destination register, and reports completion with result and flags.

Parameters:
N, 16, data width; must match the register file width.
ADDR_W, 3, register address width (8 registers); fixed at 3.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
instr_valid  input  1  instruction offered.
instr_ready  output  1  high only in IDLE.
instr_op  input  3  opcode (see Behaviour).
instr_rd  input  ADDR_W  destination register.
instr_rs1  input  ADDR_W  source A register.
instr_rs2  input  ADDR_W  source B register.
rf_read_enable  output  1  register file read_enable.
rf_read_addr  output  ADDR_W  register file read_addr.
rf_read_data  input  N  register file read_data; valid the cycle after a read is issued.
rf_write_enable  output  1  register file write_enable.
rf_write_addr  output  ADDR_W  register file write_addr.
rf_write_data  output  N  register file write_data.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse, write-back complete.
result  output  N  last computed result; held until the next done.
flag_zero  output  1  result == 0; registered with done.
flag_carry  output  1  carry/borrow of ADD/SUB; 0 for other ops.

Behaviour:
- Reset (async, any state): FSM to IDLE; all outputs 0 except instr_ready=1; latched instruction cleared; any in-flight write is dropped.
- States: IDLE -> RD_A -> RD_B -> EXEC -> WB -> IDLE. Encoding is 3-bit binary; unused codes go to IDLE.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready at a clock edge: latch op/rd/rs1/rs2, go to RD_A.
  - instr_valid without ready is ignored.
  - Inputs may change freely after acceptance.
- RD_A: rf_read_enable=1, rf_read_addr=rs1. Next state RD_B.
- RD_B:
  - rf_read_enable=1, rf_read_addr=rs2.
  - rf_read_data now holds rs1; capture it into op_a at the edge.
  - Next state EXEC.
- EXEC:
  - rf_read_data holds rs2 and is used directly as op_b.
  - ALU result and flags are registered at the edge.
  - Next state WB.
- WB:
  - rf_write_enable=1, rf_write_addr=rd, rf_write_data=result.
  - Next state IDLE, with done=1 in that first IDLE cycle.
- Latency and throughput:
  - Acceptance edge at cycle 0; done is high in cycle 5.
  - A new instruction may be accepted in the done cycle, giving a throughput of 1 instruction per 5 cycles.
- rf_read_enable and rf_write_enable are never high together. Both are 0 in IDLE, EXEC and WB (read) / all states but WB (write).
- Opcodes:
  - 0 ADD: {carry,result}=a+b, computed in N+1 bits.
  - 1 SUB: result=a-b; flag_carry=1 when a<b (unsigned borrow).
  - 2 AND, 3 OR, 4 XOR.
  - 5 SHL: a<<b[3:0], logical.
  - 6 SHR: a>>b[3:0], logical.
  - 7 MOV: result=a; b is still read but ignored.
- Register aliasing:
  - rs1==rs2 is legal and both reads are performed.
  - rd==rs1 or rd==rs2 is legal; sources are fully read before WB, so no hazard.
- Between instructions: result and flags hold their values; done is low except for its pulse.
- Reset asserted mid-instruction: no write-back and no done pulse. The register file is reset by the same rst.

Decomposition:
- Shared package reg_alu_pkg holds:
  - opcode localparams OP_ADD..OP_MOV (3-bit);
  - state encoding S_IDLE..S_WB;
  - ADDR_W=3.
- One combinational sub-module, alu_comb #(N): inputs a, b, op; outputs y, carry.
- The FSM, operand capture and register-file port drive stay in reg_alu_sequencer.

Test Plan:
- Reset then preload: rst pulse, then preload R1=0x0005, R2=0x0003 via a shadow writer. ADD rd=3, rs1=1, rs2=2 -> done in cycle 5; result=0x0008; R3=0x0008; zero=0; carry=0.
- Carry and borrow, with R1=0xFFFF and R2=0x0001:
  - ADD into R4 -> result=0x0000, zero=1, carry=1.
  - SUB R2-R1 into R5 -> result=0x0002, carry=1.
- Aliasing: R6=0x00F0. XOR rd=6, rs1=6, rs2=6 -> R6=0x0000, zero=1. Port trace shows reads of 6 in RD_A and RD_B, and a write to 6 in WB only.
- Shifts: R1=0x0001, R7=0x0014 (b[3:0]=4) -> SHL gives 0x0010; then SHR of 0x8000 by 15 gives 0x0001.
- Handshake: hold instr_valid high with two queued instructions. Accepted exactly at cycles 0 and 5; instr_ready=0 and busy=1 in cycles 1-4.
- Reset mid-op: assert rst during EXEC -> next cycle in IDLE; rf_write_enable never pulses; done=0; all outputs 0.
